// File: rtl/menu_selector_pkg.sv
// menu_selector_pkg: shared top-level FSM codes, keypad key codes and helpers
package menu_selector_pkg;
  typedef enum logic [2:0] {OFF, WLCM, CH, GAME, WL, PA} top_state_t;
  localparam int KEY_W = 5;
  localparam logic [KEY_W-1:0] K_LEFT = 5'd4;
  localparam logic [KEY_W-1:0] K_OK = 5'd5;
  localparam logic [KEY_W-1:0] K_RIGHT = 5'd6;
  function automatic int max2(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/menu_selector_repeat_timer.sv
// repeat_timer: counts while enabled, pulses done at target and restarts from zero; cleared when disabled
module repeat_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] target,
  output logic         done
);
  logic [W-1:0] cnt;
  assign done = en && cnt == target;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= (!en || done) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/menu_selector.sv
// menu_selector: keypad-driven index selector with saturate/wrap, hold-to-repeat, confirm lock and range recovery
module menu_selector
  import menu_selector_pkg::*;
#(
  parameter int N_OPTS       = 5,
  parameter int SEL_W        = 3,
  parameter int STATE_W      = 3,
  parameter int ACTIVE_STATE = int'(CH),
  parameter int WRAP         = 0,
  parameter int KEY_LEFT     = int'(K_LEFT),
  parameter int KEY_RIGHT    = int'(K_RIGHT),
  parameter int KEY_OK       = int'(K_OK),
  parameter int DEFAULT_SEL  = 0,
  parameter int REPEAT_DLY   = 25000000,
  parameter int REPEAT_RATE  = 6250000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               keypad_pressed,
  input  logic [KEY_W-1:0]   key,
  input  logic [STATE_W-1:0] presente,
  output logic [SEL_W-1:0]   sel,
  output logic               sel_changed,
  output logic               confirm,
  output logic               locked
);
  localparam int TW = $clog2(max2(REPEAT_DLY, REPEAT_RATE) + 1);
  localparam logic [SEL_W-1:0] LAST = SEL_W'(N_OPTS - 1);
  localparam logic [SEL_W-1:0] DEF = SEL_W'(DEFAULT_SEL);
  localparam logic [TW-1:0] DLY_T = TW'(REPEAT_DLY == 0 ? 0 : REPEAT_DLY - 1);
  localparam logic [TW-1:0] RATE_T = TW'(REPEAT_RATE - 1);
  typedef enum logic [1:0] {IDLE, HOLD, REPEAT, WAIT_REL} st_t;
  st_t st;
  logic [KEY_W-1:0] held;
  logic [SEL_W-1:0] nxt;
  logic armed, active, same, is_left, is_right, is_ok, is_dir, cnt_en, done, recover, do_step;
  always_comb begin
    active = presente == STATE_W'(ACTIVE_STATE) && !locked;
    is_left = key == KEY_W'(KEY_LEFT);
    is_right = key == KEY_W'(KEY_RIGHT);
    is_ok = key == KEY_W'(KEY_OK);
    is_dir = is_left || is_right;
    same = keypad_pressed && key == held;
    cnt_en = active && same && (st == REPEAT || (st == HOLD && REPEAT_DLY != 0));
    recover = 32'(sel) >= N_OPTS;
    do_step = active && keypad_pressed && is_dir &&
              ((st == IDLE && armed) || ((st == HOLD || st == REPEAT) && same && done));
    nxt = is_right ? (sel == LAST ? (WRAP != 0 ? '0 : LAST) : sel + 1'b1)
                   : (sel == '0 ? (WRAP != 0 ? LAST : '0) : sel - 1'b1);
  end
  repeat_timer #(.W(TW)) u_timer (
    .clk(clk),
    .rst(rst),
    .en(cnt_en),
    .target(st == HOLD ? DLY_T : RATE_T),
    .done(done)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st <= IDLE;
      sel <= DEF;
      sel_changed <= 1'b0;
      confirm <= 1'b0;
      locked <= 1'b0;
      held <= '0;
      armed <= 1'b0;
    end else begin
      sel_changed <= recover || (do_step && nxt != sel);
      sel <= recover ? DEF : (do_step ? nxt : sel);
      confirm <= 1'b0;
      if (!keypad_pressed) armed <= 1'b1;
      if (locked && presente != STATE_W'(ACTIVE_STATE)) locked <= 1'b0;
      if (!active) st <= IDLE;
      else case (st)
        IDLE: if (keypad_pressed && armed) begin
          held <= key;
          st <= is_dir ? HOLD : WAIT_REL;
          if (is_ok && !recover) begin
            confirm <= 1'b1;
            locked <= 1'b1;
          end
        end
        HOLD: st <= !same ? (keypad_pressed ? WAIT_REL : IDLE) : (done ? REPEAT : HOLD);
        REPEAT: st <= !same ? (keypad_pressed ? WAIT_REL : IDLE) : REPEAT;
        default: if (!keypad_pressed) st <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_menu_selector.sv
// tb_menu_selector: scoreboard bench driving a saturating and a wrapping selector with identical keypad stimulus
module tb_menu_selector;
  import menu_selector_pkg::*;
  logic clk = 1'b0, rst = 1'b1, kp = 1'b0;
  logic [4:0] key = '0;
  logic [2:0] pres = 3'd2;
  logic [2:0] sel_a, sel_b;
  logic chg_a, chg_b, cf_a, cf_b, lk_a, lk_b;
  logic [5:0] obs_a, obs_b;
  typedef struct { logic [5:0] a; logic [5:0] b; string n; } exp_t;
  exp_t q[$];
  exp_t e;
  int n_chk = 0, n_pass = 0;
  assign obs_a = {sel_a, chg_a, cf_a, lk_a};
  assign obs_b = {sel_b, chg_b, cf_b, lk_b};
  always #5 clk = ~clk;
  menu_selector #(.WRAP(0), .REPEAT_DLY(10), .REPEAT_RATE(4)) dut (
    .clk(clk), .rst(rst), .keypad_pressed(kp), .key(key), .presente(pres),
    .sel(sel_a), .sel_changed(chg_a), .confirm(cf_a), .locked(lk_a)
  );
  menu_selector #(.WRAP(1), .REPEAT_DLY(10), .REPEAT_RATE(4)) dut_w (
    .clk(clk), .rst(rst), .keypad_pressed(kp), .key(key), .presente(pres),
    .sel(sel_b), .sel_changed(chg_b), .confirm(cf_b), .locked(lk_b)
  );
  function automatic logic [5:0] o(input int s, input bit c, input bit f, input bit l);
    return {3'(s), c, f, l};
  endfunction
  task automatic tick(input bit p, input logic [4:0] k, input logic [2:0] s);
    kp = p;
    key = k;
    pres = s;
    @(posedge clk);
    #1;
  endtask
  task automatic apply_reset();
    rst = 1'b1;
    #1;
    rst = 1'b0;
    tick(1'b0, 5'd0, 3'd2);
  endtask
  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      q.push_back('{o(0, 0, 0, 0), o(0, 0, 0, 0), i == 0 ? "reset" : "reset_idle"});
      if (i == 1) begin
        rst = 1'b0;
        tick(1'b0, 5'd0, 3'd2);
      end
      e = q.pop_front();
      n_chk++;
      if ({obs_a, obs_b} !== {e.a, e.b})
        $display("FAIL %s: got a=%b b=%b want a=%b b=%b", e.n, obs_a, obs_b, e.a, e.b);
      else n_pass++;
    end
  endtask
  task automatic test_step();
    for (int i = 1; i <= 3; i++)
      for (int j = 0; j < 2; j++) begin
        q.push_back('{o(i, j == 0, 0, 0), o(i, j == 0, 0, 0), j == 0 ? "step_press" : "step_release"});
        tick(j == 0, K_RIGHT, 3'd2);
        e = q.pop_front();
        n_chk++;
        if ({obs_a, obs_b} !== {e.a, e.b})
          $display("FAIL %s[%0d]: got a=%b b=%b want a=%b b=%b", e.n, i, obs_a, obs_b, e.a, e.b);
        else n_pass++;
      end
  endtask
  task automatic test_wrap();
    int sa[6] = '{4, 4, 4, 4, 3, 3};
    bit ca[6] = '{1, 0, 0, 0, 1, 0};
    int sb[6] = '{4, 4, 0, 0, 4, 4};
    bit cb[6] = '{1, 0, 1, 0, 1, 0};
    for (int i = 0; i < 6; i++) begin
      q.push_back('{o(sa[i], ca[i], 0, 0), o(sb[i], cb[i], 0, 0), "wrap_edge"});
      tick(i % 2 == 0, i < 4 ? K_RIGHT : K_LEFT, 3'd2);
      e = q.pop_front();
      n_chk++;
      if ({obs_a, obs_b} !== {e.a, e.b})
        $display("FAIL %s[%0d]: got a=%b b=%b want a=%b b=%b", e.n, i, obs_a, obs_b, e.a, e.b);
      else n_pass++;
    end
  endtask
  task automatic test_repeat();
    int s;
    bit c;
    apply_reset();
    for (int t = 1; t <= 23; t++) begin
      s = int'(t >= 1) + int'(t >= 11) + int'(t >= 15) + int'(t >= 19);
      c = (t == 1 || t == 11 || t == 15 || t == 19);
      q.push_back('{o(s, c, 0, 0), o(s, c, 0, 0), t == 23 ? "repeat_release" : "repeat_hold"});
      tick(t <= 22, K_RIGHT, 3'd2);
      e = q.pop_front();
      n_chk++;
      if ({obs_a, obs_b} !== {e.a, e.b})
        $display("FAIL %s[t=%0d]: got a=%b b=%b want a=%b b=%b", e.n, t, obs_a, obs_b, e.a, e.b);
      else n_pass++;
    end
  endtask
  task automatic test_lock();
    bit p[7] = '{1, 1, 0, 1, 0, 0, 0};
    logic [4:0] k[7] = '{K_OK, K_OK, K_OK, K_RIGHT, K_RIGHT, 5'd0, 5'd0};
    bit f[7] = '{1, 0, 0, 0, 0, 0, 0};
    bit l[7] = '{1, 1, 1, 1, 1, 0, 0};
    for (int i = 0; i < 7; i++) begin
      q.push_back('{o(4, 0, f[i], l[i]), o(4, 0, f[i], l[i]), "lock"});
      tick(p[i], k[i], i == 5 ? 3'd3 : 3'd2);
      e = q.pop_front();
      n_chk++;
      if ({obs_a, obs_b} !== {e.a, e.b})
        $display("FAIL %s[%0d]: got a=%b b=%b want a=%b b=%b", e.n, i, obs_a, obs_b, e.a, e.b);
      else n_pass++;
    end
  endtask
  task automatic test_inactive();
    for (int i = 1; i <= 16; i++) begin
      q.push_back('{o(i >= 3 ? 3 : 4, i == 3, 0, 0), o(i >= 3 ? 3 : 4, i == 3, 0, 0), "inactive"});
      tick(!(i == 2 || i >= 15), K_LEFT, (i == 3 || i == 16) ? 3'd2 : 3'd3);
      e = q.pop_front();
      n_chk++;
      if ({obs_a, obs_b} !== {e.a, e.b})
        $display("FAIL %s[%0d]: got a=%b b=%b want a=%b b=%b", e.n, i, obs_a, obs_b, e.a, e.b);
      else n_pass++;
    end
  endtask
  task automatic test_reset_mid_repeat();
    apply_reset();
    for (int t = 1; t <= 15; t++) tick(1'b1, K_RIGHT, 3'd2);
    q.push_back('{o(3, 1, 0, 0), o(3, 1, 0, 0), "pre_reset_repeat"});
    e = q.pop_front();
    n_chk++;
    if ({obs_a, obs_b} !== {e.a, e.b})
      $display("FAIL %s: got a=%b b=%b want a=%b b=%b", e.n, obs_a, obs_b, e.a, e.b);
    else n_pass++;
    #2;
    rst = 1'b1;
    q.push_back('{o(0, 0, 0, 0), o(0, 0, 0, 0), "async_reset"});
    #1;
    e = q.pop_front();
    n_chk++;
    if ({obs_a, obs_b} !== {e.a, e.b})
      $display("FAIL %s: got a=%b b=%b want a=%b b=%b", e.n, obs_a, obs_b, e.a, e.b);
    else n_pass++;
    #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      q.push_back('{o(i == 5, i == 5, 0, 0), o(i == 5, i == 5, 0, 0), "held_after_reset"});
      tick(i != 4, K_RIGHT, 3'd2);
      e = q.pop_front();
      n_chk++;
      if ({obs_a, obs_b} !== {e.a, e.b})
        $display("FAIL %s[%0d]: got a=%b b=%b want a=%b b=%b", e.n, i, obs_a, obs_b, e.a, e.b);
      else n_pass++;
    end
  endtask
  initial begin
    test_reset();
    test_step();
    test_wrap();
    test_repeat();
    test_lock();
    test_inactive();
    test_reset_mid_repeat();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
